traffic_analyzer_snapshot_ctrl: RTL and testbench

Sequences the `freeze_stats` control bit of one `traffic_analyzer_gmii` instance so that software reads a coherent statistics snapshot. Snapshots are triggered by a software request or a programmable periodic tick. The block holds the freeze until the GMII line has drained and the analyzer registers have settled, then signals validity and keeps the snapshot stable until it is acknowledged or a timeout expires. It sits in the GMII `clk` domain between the CPU register block and the analyzer control inputs.

---
 rtl/traffic_analyzer_snapshot_ctrl_if.sv | 36 +++
 rtl/traffic_analyzer_snapshot_ctrl.sv | 172 +++++++++++++++++
 tb/tb_traffic_analyzer_snapshot_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_analyzer_snapshot_ctrl_if.sv
// Control/status bundle between the CPU register block, the GMII monitor and the snapshot sequencer.
// master: register block / line side; slave: traffic_analyzer_snapshot_ctrl.
interface traffic_analyzer_snapshot_ctrl_if #(
    parameter int unsigned C_PERIOD_WIDTH  = 32,
    parameter int unsigned C_TIMEOUT_WIDTH = 24
);
    logic                       enable;
    logic                       snap_req;
    logic [C_PERIOD_WIDTH-1:0]  period;
    logic [C_TIMEOUT_WIDTH-1:0] hold_timeout;
    logic                       snap_ack;
    logic                       gmii_en;
    logic [47:0]                sec;
    logic [29:0]                nsec;

    logic                       freeze_stats;
    logic                       snap_valid;
    logic                       busy;
    logic [15:0]                snap_seq;
    logic [15:0]                snap_missed;
    logic                       hold_expired;
    logic [47:0]                snap_sec;
    logic [29:0]                snap_nsec;

    modport master (
        output enable, snap_req, period, hold_timeout, snap_ack, gmii_en, sec, nsec,
        input  freeze_stats, snap_valid, busy, snap_seq, snap_missed, hold_expired,
               snap_sec, snap_nsec
    );

    modport slave (
        input  enable, snap_req, period, hold_timeout, snap_ack, gmii_en, sec, nsec,
        output freeze_stats, snap_valid, busy, snap_seq, snap_missed, hold_expired,
               snap_sec, snap_nsec
    );
endinterface

// File: rtl/traffic_analyzer_snapshot_ctrl.sv
// Sequences freeze_stats so software reads a coherent analyzer snapshot (request or periodic trigger).
// Optional timestamp latch of sec/nsec at trigger: define SNAPSHOT_TIMESTAMP_EN.
module traffic_analyzer_snapshot_ctrl #(
    parameter int unsigned C_PERIOD_WIDTH  = 32,
    parameter int unsigned C_TIMEOUT_WIDTH = 24,
    parameter int unsigned C_SETTLE_CYCLES = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    traffic_analyzer_snapshot_ctrl_if.slave bus
);
    localparam int unsigned PW       = C_PERIOD_WIDTH;
    localparam int unsigned TW       = C_TIMEOUT_WIDTH;
    localparam int unsigned SW       = 4;
    localparam int unsigned CNT_W    = 16;
    localparam logic [SW-1:0] SETTLE_INIT = SW'(C_SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_HOLD    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [PW-1:0]     period_cnt, period_cnt_next;
    logic [SW-1:0]     settle_cnt, settle_next;
    logic [TW-1:0]     hold_cnt, hold_next;
    logic [CNT_W-1:0]  snap_seq, seq_next;
    logic [CNT_W-1:0]  snap_missed, missed_next;
    logic              hold_expired, expired_next;
    logic              freeze_stats, snap_valid, busy;
    logic              tick, trigger, latch_ts;

    // Periodic tick; a shrunk period fires as soon as the count is at or past it
    always_comb begin
        tick            = 1'b0;
        period_cnt_next = period_cnt + PW'(1);
        if (!bus.enable || bus.period == '0) begin
            period_cnt_next = '0;
        end else if (period_cnt >= bus.period - PW'(1)) begin
            tick            = 1'b1;
            period_cnt_next = '0;
        end
    end

    assign trigger = bus.enable & (bus.snap_req | tick);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and next-value logic for counters and flags
    always_comb begin
        state_next   = state;
        settle_next  = settle_cnt;
        hold_next    = hold_cnt;
        seq_next     = snap_seq;
        expired_next = hold_expired;
        missed_next  = snap_missed;
        latch_ts     = 1'b0;

        if (trigger && state != ST_IDLE && snap_missed != {CNT_W{1'b1}}) begin
            missed_next = snap_missed + CNT_W'(1);
        end

        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_next  = ST_DRAIN;
                    settle_next = SETTLE_INIT;
                    latch_ts    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (!bus.enable) begin
                    state_next = ST_RELEASE;
                end else if (bus.gmii_en) begin
                    settle_next = SETTLE_INIT;
                end else if (settle_cnt <= SW'(1)) begin
                    state_next   = ST_HOLD;
                    settle_next  = '0;
                    seq_next     = snap_seq + CNT_W'(1);
                    expired_next = 1'b0;
                    hold_next    = '0;
                end else begin
                    settle_next = settle_cnt - SW'(1);
                end
            end
            ST_HOLD: begin
                // An ack coinciding with the timeout wins, leaving hold_expired clear
                if (!bus.enable || bus.snap_ack) begin
                    state_next = ST_RELEASE;
                end else if (bus.hold_timeout != '0 &&
                             hold_cnt == bus.hold_timeout - TW'(1)) begin
                    state_next   = ST_RELEASE;
                    expired_next = 1'b1;
                end else begin
                    hold_next = hold_cnt + TW'(1);
                end
            end
            ST_RELEASE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered datapath and outputs, derived from the next state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_cnt   <= '0;
            settle_cnt   <= '0;
            hold_cnt     <= '0;
            snap_seq     <= '0;
            snap_missed  <= '0;
            hold_expired <= 1'b0;
            freeze_stats <= 1'b0;
            snap_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            period_cnt   <= period_cnt_next;
            settle_cnt   <= settle_next;
            hold_cnt     <= hold_next;
            snap_seq     <= seq_next;
            snap_missed  <= missed_next;
            hold_expired <= expired_next;
            freeze_stats <= (state_next == ST_DRAIN) || (state_next == ST_HOLD);
            snap_valid   <= (state_next == ST_HOLD);
            busy         <= (state_next != ST_IDLE);
        end
    end

    assign bus.freeze_stats = freeze_stats;
    assign bus.snap_valid   = snap_valid;
    assign bus.busy         = busy;
    assign bus.snap_seq     = snap_seq;
    assign bus.snap_missed  = snap_missed;
    assign bus.hold_expired = hold_expired;

`ifdef SNAPSHOT_TIMESTAMP_EN
    logic [47:0] snap_sec;
    logic [29:0] snap_nsec;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            snap_sec  <= '0;
            snap_nsec <= '0;
        end else if (latch_ts) begin
            snap_sec  <= bus.sec;
            snap_nsec <= bus.nsec;
        end
    end

    assign bus.snap_sec  = snap_sec;
    assign bus.snap_nsec = snap_nsec;
`else
    logic unused_ts;

    // Timestamp ports stay in place but read as zero when the latch is not built
    assign unused_ts     = ^{bus.sec, bus.nsec, latch_ts};
    assign bus.snap_sec  = '0;
    assign bus.snap_nsec = '0;
`endif

endmodule

// File: tb/tb_traffic_analyzer_snapshot_ctrl.sv
// Self-checking bench for traffic_analyzer_snapshot_ctrl: directed scenarios then randomized traffic,
// all checked against an event-level reference model of the snapshot protocol.
module tb_traffic_analyzer_snapshot_ctrl;
    localparam int unsigned PW     = 32;
    localparam int unsigned TW     = 24;
    localparam int unsigned SETTLE = 8;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   tests  = 0;
    int   fails  = 0;

    traffic_analyzer_snapshot_ctrl_if #(.C_PERIOD_WIDTH(PW), .C_TIMEOUT_WIDTH(TW)) bus ();

    traffic_analyzer_snapshot_ctrl #(
        .C_PERIOD_WIDTH (PW),
        .C_TIMEOUT_WIDTH(TW),
        .C_SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: snapshot lifecycle as flags plus elapsed-cycle counts
    bit          m_frozen, m_valid, m_cool, m_exp;
    int          idle_run, hold_age, m_seq, m_missed;
    longint      p_age;
    logic [47:0] m_sec;
    logic [29:0] m_nsec;

    task automatic model_reset();
        m_frozen = 0; m_valid = 0; m_cool = 0; m_exp = 0;
        idle_run = 0; hold_age = 0; m_seq = 0; m_missed = 0; p_age = 0;
        m_sec = '0; m_nsec = '0;
    endtask

    task automatic model_step();
        bit tick, trig, busy_now;
        if (!resetn) begin
            model_reset();
            return;
        end
        busy_now = m_frozen || m_cool;
        tick = 0;
        if (!bus.enable || bus.period == 0) p_age = 0;
        else if (p_age + 1 >= longint'(bus.period)) begin tick = 1; p_age = 0; end
        else p_age++;
        trig = bus.enable && (bus.snap_req || tick);
        if (trig && busy_now && m_missed < 65535) m_missed++;

        if (m_cool) begin
            m_cool = 0;
        end else if (!m_frozen) begin
            if (trig) begin
                m_frozen = 1; idle_run = 0; m_sec = bus.sec; m_nsec = bus.nsec;
            end
        end else if (!bus.enable) begin
            m_frozen = 0; m_valid = 0; m_cool = 1;
        end else if (!m_valid) begin
            idle_run = bus.gmii_en ? 0 : idle_run + 1;
            if (idle_run == SETTLE) begin
                m_valid = 1; m_seq = (m_seq + 1) % 65536; m_exp = 0; hold_age = 0;
            end
        end else begin
            hold_age++;
            if (bus.snap_ack) begin
                m_frozen = 0; m_valid = 0; m_cool = 1;
            end else if (bus.hold_timeout != 0 && hold_age == int'(bus.hold_timeout)) begin
                m_frozen = 0; m_valid = 0; m_cool = 1; m_exp = 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [47:0] es;
        logic [29:0] en;
`ifdef SNAPSHOT_TIMESTAMP_EN
        es = m_sec; en = m_nsec;
`else
        es = '0; en = '0;
`endif
        chk("freeze_stats", 64'(bus.freeze_stats), 64'(m_frozen));
        chk("snap_valid",   64'(bus.snap_valid),   64'(m_valid));
        chk("busy",         64'(bus.busy),         64'(m_frozen || m_cool));
        chk("snap_seq",     64'(bus.snap_seq),     64'(m_seq));
        chk("snap_missed",  64'(bus.snap_missed),  64'(m_missed));
        chk("hold_expired", 64'(bus.hold_expired), 64'(m_exp));
        chk("snap_sec",     64'(bus.snap_sec),     64'(es));
        chk("snap_nsec",    64'(bus.snap_nsec),    64'(en));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic pulse_req();
        bus.snap_req = 1'b1; cycle(); bus.snap_req = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.snap_ack = 1'b1; cycle(); bus.snap_ack = 1'b0;
    endtask

    initial begin
        int vcount;
        logic [47:0] exp_sec;

        bus.enable = 0; bus.snap_req = 0; bus.period = '0; bus.hold_timeout = '0;
        bus.snap_ack = 0; bus.gmii_en = 0; bus.sec = '0; bus.nsec = '0;
        model_reset();

        // Reset state
        #1;
        chk("rst_freeze", 64'(bus.freeze_stats), 64'd0);
        chk("rst_busy",   64'(bus.busy),         64'd0);
        chk("rst_seq",    64'(bus.snap_seq),     64'd0);
        check_all();
        cycles(2);
        resetn = 1'b1;
        bus.enable = 1'b1;
        cycles(5);

        // Idle line: freeze next cycle, valid SETTLE cycles later, ack releases
        bus.sec = 48'h1234; bus.nsec = 30'h55;
        pulse_req();
        bus.sec = 48'h9999; bus.nsec = 30'h0;
        chk("t1_freeze", 64'(bus.freeze_stats), 64'd1);
        chk("t1_busy",   64'(bus.busy),         64'd1);
`ifdef SNAPSHOT_TIMESTAMP_EN
        exp_sec = 48'h1234;
`else
        exp_sec = 48'h0;
`endif
        chk("t1_ts_sec", 64'(bus.snap_sec), 64'(exp_sec));
        cycles(SETTLE - 1);
        chk("t1_valid_early", 64'(bus.snap_valid), 64'd0);
        cycle();
        chk("t1_valid", 64'(bus.snap_valid), 64'd1);
        chk("t1_seq",   64'(bus.snap_seq),   64'd1);
        cycles(10);
        pulse_ack();
        chk("t1_ack_valid",  64'(bus.snap_valid),   64'd0);
        chk("t1_ack_freeze", 64'(bus.freeze_stats), 64'd0);
        chk("t1_ack_busy",   64'(bus.busy),         64'd1);
        cycle();
        chk("t1_idle_busy", 64'(bus.busy), 64'd0);

        // Line activity during drain extends it
        pulse_req();
        cycle();
        bus.gmii_en = 1'b1;
        cycles(29);
        bus.gmii_en = 1'b0;
        cycles(SETTLE - 1);
        chk("t2_valid_early", 64'(bus.snap_valid), 64'd0);
        cycle();
        chk("t2_valid", 64'(bus.snap_valid), 64'd1);
        pulse_ack();
        cycle();

        // Periodic snapshots with hold timeout
        bus.hold_timeout = TW'(5);
        bus.period = PW'(100);
        vcount = 0;
        for (int i = 0; i < 320; i++) begin
            cycle();
            if (bus.snap_valid) vcount++;
        end
        chk("t3_valid_cycles", 64'(vcount),           64'd15);
        chk("t3_seq",          64'(bus.snap_seq),     64'd5);
        chk("t3_expired",      64'(bus.hold_expired), 64'd1);
        bus.period = '0;
        bus.hold_timeout = '0;
        cycle();

        // Triggers during HOLD are missed, including a coincident req+tick
        pulse_req();
        cycles(SETTLE);
        chk("t4_valid", 64'(bus.snap_valid), 64'd1);
        bus.snap_req = 1'b1;
        cycles(3);
        bus.period = PW'(1);
        cycle();
        bus.snap_req = 1'b0;
        bus.period = '0;
        cycle();
        chk("t4_missed", 64'(bus.snap_missed), 64'd4);
        chk("t4_seq",    64'(bus.snap_seq),    64'd6);
        pulse_ack();
        cycle();
        // Coincident req+tick in IDLE: one snapshot, no miss
        bus.snap_req = 1'b1; bus.period = PW'(1);
        cycle();
        bus.snap_req = 1'b0; bus.period = '0;
        chk("t4_idle_missed", 64'(bus.snap_missed), 64'd4);
        chk("t4_idle_freeze", 64'(bus.freeze_stats), 64'd1);
        cycles(SETTLE);
        chk("t4_idle_seq", 64'(bus.snap_seq), 64'd7);
        pulse_ack();
        cycle();

        // Enable dropped during DRAIN aborts without counting
        pulse_req();
        cycle();
        bus.enable = 1'b0;
        cycle();
        chk("t5_freeze", 64'(bus.freeze_stats), 64'd0);
        chk("t5_busy",   64'(bus.busy),         64'd1);
        cycle();
        chk("t5_idle", 64'(bus.busy),     64'd0);
        chk("t5_seq",  64'(bus.snap_seq), 64'd7);
        pulse_req();
        chk("t5_ignored_busy",   64'(bus.busy),        64'd0);
        chk("t5_ignored_missed", 64'(bus.snap_missed), 64'd4);
        bus.enable = 1'b1;
        cycle();

        // Asynchronous reset while holding
        pulse_req();
        cycles(SETTLE);
        chk("t6_valid", 64'(bus.snap_valid), 64'd1);
        #1;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_freeze", 64'(bus.freeze_stats), 64'd0);
        chk("t6_rst_valid",  64'(bus.snap_valid),   64'd0);
        chk("t6_rst_seq",    64'(bus.snap_seq),     64'd0);
        chk("t6_rst_missed", 64'(bus.snap_missed),  64'd0);
        check_all();
        cycles(2);
        resetn = 1'b1;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) begin
                bus.period       = ($urandom_range(0, 3) == 0) ? PW'(0) : PW'($urandom_range(5, 80));
                bus.hold_timeout = TW'($urandom_range(0, 12));
            end
            bus.enable   = ($urandom_range(0, 59) != 0);
            bus.snap_req = ($urandom_range(0, 24) == 0);
            bus.snap_ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) bus.gmii_en = ~bus.gmii_en;
            bus.sec  = {16'($urandom), 32'($urandom)};
            bus.nsec = 30'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
